pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the RISC-V core.
- Holds the architectural PC and produces PCplus4 for the PC_mux. Captures PC_next from the mux as the next fetch address.
- Issues one outstanding request at a time to instruction memory over a valid/ready request and valid response interface.
- Presents the fetched instruction and its PC to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- XLEN, 32: address and instruction width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PC_next  in  XLEN  next PC from PC_mux
- flush  in  1  redirect: discard in-flight/held instruction, load PC_next
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  fetch address (= PC)
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  XLEN  fetched instruction word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode consumes instruction
- instr  out  XLEN  held instruction
- PC  out  XLEN  current PC
- PCplus4  out  XLEN  PC + 4, wraps modulo 2^XLEN, to PC_mux
- fetch_fault  out  1  misaligned-PC fault (only with MISALIGN_TRAP_EN; else tied 0)

Behaviour:
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD. Internal drop flag.
- Reset (rst_n low, async):
  - State S_IDLE, PC = RESET_PC, drop = 0, instr = 0.
  - Outputs: imem_req_valid = 0, instr_valid = 0, fetch_fault = 0.
- S_IDLE: unconditionally go to S_REQ on the first clk edge after reset release.
- S_REQ:
  - imem_req_valid = 1, imem_addr = PC.
  - imem_req_ready = 1 -> S_WAIT. Otherwise stay; address held stable.
- S_WAIT: imem_req_valid = 0; wait for imem_rsp_valid.
  - drop = 0: instr <= imem_rsp_data, go to S_HOLD.
  - drop = 1: discard data, clear drop, go to S_REQ.
- S_HOLD: instr_valid = 1; instr and PC stable.
  - instr_ready = 1: PC <= PC_next, go to S_REQ.
  - Fetch-to-fetch minimum period: 3 cycles (REQ, WAIT, HOLD) with zero-latency memory.
- PCplus4 is combinational from the PC register. There is no path from PC_next to any output (no loop through the mux).
- flush (highest priority, any state except S_IDLE): PC <= PC_next, instr_valid falls on the next cycle.
  - In S_REQ without imem_req_ready: stay in S_REQ; the new PC is presented next cycle.
  - In S_REQ with imem_req_ready in the same cycle: request at the old PC is accepted; go to S_WAIT with drop = 1.
  - In S_WAIT: drop <= 1, stay in S_WAIT. If imem_rsp_valid arrives in the same cycle, discard it and go to S_REQ with drop = 0.
  - In S_HOLD: go to S_REQ. Same result whether or not instr_ready is also high.
  - Flush in S_IDLE is ignored.
- imem_rsp_valid outside S_WAIT is ignored.
- Reset asserted mid-transaction: immediate return to reset values. Any late memory response arrives in S_IDLE or S_REQ and is ignored.

Optional Feature:
- Macro: PC_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A PC load whose PC_next[1:0] != 0 sets fetch_fault (sticky until reset).
  - The block moves to S_IDLE and stays there; imem_req_valid and instr_valid stay 0.
  - The faulting value is still loaded and visible on PC.
- Undefined:
  - PC_next[1:0] is forced to 2'b00 on every load.
  - fetch_fault is tied to 0.

Test Plan:
- Reset RESET_PC = 32'h0000_0100, memory always ready, rsp_data = 32'h0000_0013, PC_next = PCplus4 -> first imem_addr = 32'h100 one cycle after reset release; instr_valid with PC = 32'h100, then 32'h104, 32'h108.
- imem_req_ready held low for 5 cycles in S_REQ -> imem_req_valid held 1 and imem_addr stable for 5 cycles; S_WAIT is entered only on the ready cycle.
- instr_ready low for 4 cycles in S_HOLD with instr = 32'hDEADBEEF -> instr and PC unchanged; no new request is issued.
- flush with PC_next = 32'hBAAFDAAC while in S_WAIT, response arriving 2 cycles later -> response dropped; next request has imem_addr = 32'hBAAFDAAC; instr_valid never shows the dropped word.
- PC at 32'hFFFF_FFFC -> PCplus4 = 32'h0000_0000 (wrap).
- With PC_FETCH_MISALIGN_TRAP_EN: PC_next = 32'h0000_0102 on handshake -> fetch_fault = 1 and no further imem_req_valid. Without the macro: the next imem_addr is 32'h0000_0100.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and single-outstanding instruction
// fetch sequencer. Holds the architectural PC, offers PCplus4 to the PC mux,
// fetches one word at a time from instruction memory and hands it to decode.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. A valid, once raised, is held with its payload stable until
// that transfer (or a flush/reset). imem_rsp_valid has no ready; it is only
// consumed while waiting for a response.
//
// Optional feature macro: PC_FETCH_MISALIGN_TRAP_EN
//   defined   : loading a PC with PC_next[1:0] != 0 sets a sticky fetch_fault,
//               parks the sequencer in S_IDLE, and still loads the bad PC.
//   undefined : PC_next[1:0] is forced to 2'b00 on load; fetch_fault is 0.
module pc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PC_next,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCplus4,
  output logic            fetch_fault,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] w_pc_load_val;
  logic            r_drop;
  logic            w_drop_nxt;
  logic            w_pc_load;
  logic            w_instr_load;
  logic            w_halted;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic r_fault;
  logic w_fault_set;

  // The faulting PC is loaded unmodified so software can see it.
  assign w_pc_load_val = PC_next;
  assign w_halted      = r_fault;
  assign fetch_fault   = r_fault;
`else
  // Low address bits are cleared so fetches are always word aligned.
  assign w_pc_load_val = {PC_next[XLEN-1:2], PC_next[1:0] & 2'b00};
  assign w_halted      = 1'b0;
  assign fetch_fault   = 1'b0;
`endif

  // Next-state, PC-load, drop and capture decisions; flush outranks everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_drop_nxt   = r_drop;
    w_pc_load    = 1'b0;
    w_instr_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_halted) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (flush) begin
          w_pc_load = 1'b1;
          // A request accepted this cycle still carries the old PC, so its
          // response must be thrown away.
          if (imem_req_ready) begin
            w_state_nxt = S_WAIT;
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_pc_load = 1'b1;
          if (imem_rsp_valid) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_instr_load = 1'b1;
            w_state_nxt  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush || instr_ready) begin
          w_pc_load   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
    endcase
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    w_fault_set = w_pc_load && (PC_next[1:0] != 2'b00);
    if (w_fault_set) begin
      w_state_nxt  = S_IDLE;
      w_drop_nxt   = 1'b0;
      w_instr_load = 1'b0;
    end
`endif
  end

  // State, PC, drop flag and held instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_pc_load)    r_pc    <= w_pc_load_val;
      if (w_instr_load) r_instr <= imem_rsp_data;
    end
  end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  // Sticky misalignment fault, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_fault <= 1'b0;
    else if (w_fault_set) r_fault <= 1'b1;
  end
`endif

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_addr      = r_pc;
  assign instr_valid    = (r_state == S_HOLD);
  assign instr          = r_instr;
  assign PC             = r_pc;
  assign PCplus4        = r_pc + XLEN'(4);
  assign dbg_state      = r_state;

endmodule
